// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and encodings for the ALU sequencing controller.
// Holds the FSM state enum, command op codes, ALUop codes and write-back
// source (vsel) codes, plus the op -> ALUop mapping used in EXEC.
package alu_seq_pkg;

    typedef enum logic [2:0] {
        S_WAIT,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WR_C,
        S_WR_IMM
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_MVN  = 3'b011;
    localparam logic [2:0] OP_MOV  = 3'b100;
    localparam logic [2:0] OP_MOVI = 3'b101;
    localparam logic [2:0] OP_CMP  = 3'b110;
    localparam logic [2:0] OP_RSV  = 3'b111;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_NOT = 2'b11;

    localparam logic [1:0] VSEL_C   = 2'b00;
    localparam logic [1:0] VSEL_IMM = 2'b10;

    function automatic logic [1:0] alu_code(input logic [2:0] op);
        logic [1:0] code;
        case (op)
            OP_SUB,
            OP_CMP:  code = ALU_SUB;
            OP_AND:  code = ALU_AND;
            OP_MVN:  code = ALU_NOT;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: multi-cycle control FSM for the register-file/ALU datapath.
// Accepts one command per handshake (s while w=1), then sequences operand
// reads, ALU execute and write-back.
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   s, op, rn, rm, rd   start request and command fields
//   shift_in, imm8      shift code for B operand, immediate for MOVI
//   w                   idle/ready (WAIT state)
//   readnum, writenum   register-file addresses
//   write, loada, loadb, loadc, loads   register enables
//   asel, bsel, vsel    datapath source selects
//   shift, ALUop        shifter and ALU controls
//   sximm               captured imm8 sign-extended to DW bits
module alu_seq_ctrl
    import alu_seq_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          s,
    input  logic [2:0]    op,
    input  logic [2:0]    rn,
    input  logic [2:0]    rm,
    input  logic [2:0]    rd,
    input  logic [1:0]    shift_in,
    input  logic [7:0]    imm8,
    output logic          w,
    output logic [2:0]    readnum,
    output logic [2:0]    writenum,
    output logic          write,
    output logic          loada,
    output logic          loadb,
    output logic          loadc,
    output logic          loads,
    output logic          asel,
    output logic          bsel,
    output logic [1:0]    vsel,
    output logic [1:0]    shift,
    output logic [1:0]    ALUop,
    output logic [DW-1:0] sximm
);

    state_t     r_state;
    state_t     w_next;
    logic [2:0] r_op;
    logic [2:0] r_rn;
    logic [2:0] r_rm;
    logic [2:0] r_rd;
    logic [1:0] r_shift;
    logic [7:0] r_imm8;
    logic       w_accept;

    assign w_accept = (r_state == S_WAIT) && s;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_WAIT;
            r_op    <= '0;
            r_rn    <= '0;
            r_rm    <= '0;
            r_rd    <= '0;
            r_shift <= '0;
            r_imm8  <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_op    <= op;
                r_rn    <= rn;
                r_rm    <= rm;
                r_rd    <= rd;
                r_shift <= shift_in;
                r_imm8  <= imm8;
            end
        end
    end

    // The path is chosen from the live op on the accepting edge; every later
    // decision uses the captured op.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WAIT: begin
                if (s) begin
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_CMP: w_next = S_GET_A;
                        OP_MVN, OP_MOV:                 w_next = S_GET_B;
                        OP_MOVI:                        w_next = S_WR_IMM;
                        // Reserved op spends its single busy cycle in EXEC
                        // with every enable suppressed.
                        default:                        w_next = S_EXEC;
                    endcase
                end
            end
            S_GET_A:  w_next = S_GET_B;
            S_GET_B:  w_next = S_EXEC;
            S_EXEC:   w_next = (r_op == OP_CMP || r_op == OP_RSV) ? S_WAIT : S_WR_C;
            S_WR_C:   w_next = S_WAIT;
            S_WR_IMM: w_next = S_WAIT;
            default:  w_next = S_WAIT;
        endcase
    end

    always_comb begin
        w        = 1'b0;
        readnum  = '0;
        writenum = '0;
        write    = 1'b0;
        loada    = 1'b0;
        loadb    = 1'b0;
        loadc    = 1'b0;
        loads    = 1'b0;
        asel     = 1'b0;
        bsel     = 1'b0;
        vsel     = '0;
        shift    = '0;
        ALUop    = '0;
        case (r_state)
            S_WAIT: w = 1'b1;
            S_GET_A: begin
                readnum = r_rn;
                loada   = 1'b1;
            end
            S_GET_B: begin
                readnum = r_rm;
                loadb   = 1'b1;
            end
            S_EXEC: begin
                if (r_op != OP_RSV) begin
                    shift = r_shift;
                    ALUop = alu_code(r_op);
                    loads = 1'b1;
                    loadc = (r_op != OP_CMP);
                    asel  = (r_op == OP_MOV);
                end
            end
            S_WR_C: begin
                writenum = r_rd;
                vsel     = VSEL_C;
                write    = 1'b1;
            end
            S_WR_IMM: begin
                writenum = r_rd;
                vsel     = VSEL_IMM;
                bsel     = 1'b1;
                write    = 1'b1;
            end
            default: ;
        endcase
    end

    assign sximm = {{(DW-8){r_imm8[7]}}, r_imm8};

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: self-checking bench for alu_seq_ctrl. Each command's
// expected per-cycle output trace is derived from the command's phase list
// (read A?, read B, execute, write C / write immediate).
module tb_alu_seq_ctrl;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          s;
    logic [2:0]    op, rn, rm, rd;
    logic [1:0]    shift_in;
    logic [7:0]    imm8;
    logic          w;
    logic [2:0]    readnum, writenum;
    logic          write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]    vsel, shift, ALUop;
    logic [DW-1:0] sximm;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic       w;
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write;
        logic       loada;
        logic       loadb;
        logic       loadc;
        logic       loads;
        logic       asel;
        logic       bsel;
        logic [1:0] vsel;
        logic [1:0] shift;
        logic [1:0] aluop;
    } ov_t;

    ov_t exp_q[$];

    alu_seq_ctrl #(.DW(DW)) dut (
        .clk(clk), .reset(reset), .s(s), .op(op), .rn(rn), .rm(rm), .rd(rd),
        .shift_in(shift_in), .imm8(imm8), .w(w), .readnum(readnum),
        .writenum(writenum), .write(write), .loada(loada), .loadb(loadb),
        .loadc(loadc), .loads(loads), .asel(asel), .bsel(bsel), .vsel(vsel),
        .shift(shift), .ALUop(ALUop), .sximm(sximm)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic ov_t obs();
        return {w, readnum, writenum, write, loada, loadb, loadc, loads,
                asel, bsel, vsel, shift, ALUop};
    endfunction

    function automatic ov_t idle_vec();
        ov_t c = '0;
        c.w = 1'b1;
        return c;
    endfunction

    function automatic logic [DW-1:0] sext(input logic [7:0] v);
        logic signed [DW-1:0] t;
        t = $signed(v);
        return t;
    endfunction

    function automatic logic [1:0] alu_of(input logic [2:0] o);
        case (o)
            3'd1, 3'd6: return 2'b01;
            3'd2:       return 2'b10;
            3'd3:       return 2'b11;
            default:    return 2'b00;
        endcase
    endfunction

    // Reference trace: one entry per busy cycle, built from the command's phases.
    function automatic void model(input logic [2:0] o, input logic [2:0] a,
                                  input logic [2:0] b, input logic [2:0] d,
                                  input logic [1:0] sh);
        ov_t c;
        bit  reads_a  = (o == 3'd0 || o == 3'd1 || o == 3'd2 || o == 3'd6);
        bit  uses_alu = (o != 3'd5 && o != 3'd7);
        bit  wr_c     = (o <= 3'd4);
        exp_q.delete();
        if (o == 3'd5) begin
            c = '0; c.writenum = d; c.vsel = 2'b10; c.bsel = 1'b1; c.write = 1'b1;
            exp_q.push_back(c);
        end else if (!uses_alu) begin
            c = '0;
            exp_q.push_back(c);
        end else begin
            if (reads_a) begin
                c = '0; c.readnum = a; c.loada = 1'b1;
                exp_q.push_back(c);
            end
            c = '0; c.readnum = b; c.loadb = 1'b1;
            exp_q.push_back(c);
            c = '0; c.shift = sh; c.aluop = alu_of(o); c.loads = 1'b1;
            c.loadc = (o != 3'd6); c.asel = (o == 3'd4);
            exp_q.push_back(c);
            if (wr_c) begin
                c = '0; c.writenum = d; c.write = 1'b1;
                exp_q.push_back(c);
            end
        end
    endfunction

    // Called at posedge+1 with the FSM in WAIT. s_busy: 0 low, 1 high, 2 random
    // while busy. hold keeps s high on return so the next call issues back-to-back.
    task automatic exec_cmd(input logic [2:0] o, input logic [2:0] a,
                            input logic [2:0] b, input logic [2:0] d,
                            input logic [1:0] sh, input logic [7:0] im,
                            input int s_busy, input bit hold,
                            output int lat, output int nwr);
        ov_t o_v;
        int  nexp;
        lat = 0;
        nwr = 0;
        checks++;
        if (w !== 1'b1) begin
            failures++;
            $display("FAIL ready_before_cmd op=%0d: w=%b required 1", o, w);
        end
        model(o, a, b, d, sh);
        nexp = exp_q.size();
        op = o; rn = a; rm = b; rd = d; shift_in = sh; imm8 = im; s = 1'b1;
        for (int i = 0; i < nexp; i++) begin
            @(posedge clk); #1;
            op = 3'($urandom); rn = 3'($urandom); rm = 3'($urandom);
            rd = 3'($urandom); shift_in = 2'($urandom); imm8 = 8'($urandom);
            s = (s_busy == 0) ? 1'b0 : (s_busy == 1) ? 1'b1 : 1'($urandom);
            o_v = obs();
            if (o_v.w === 1'b0) lat++;
            if (o_v.write === 1'b1) nwr++;
            checks++;
            if (o_v !== exp_q[i]) begin
                failures++;
                $display("FAIL trace op=%0d cyc=%0d: got %h required %h", o, i + 1, o_v, exp_q[i]);
            end
            checks++;
            if (sximm !== sext(im)) begin
                failures++;
                $display("FAIL sximm op=%0d cyc=%0d: got %h required %h", o, i + 1, sximm, sext(im));
            end
        end
        @(posedge clk); #1;
        s = hold;
        checks++;
        if (obs() !== idle_vec()) begin
            failures++;
            $display("FAIL return_wait op=%0d: got %h required %h", o, obs(), idle_vec());
        end
    endtask

    task automatic test_reset();
        s = 1'b0; op = '0; rn = '0; rm = '0; rd = '0; shift_in = '0; imm8 = '0;
        reset = 1'b1;
        #1;
        checks++;
        if (obs() !== idle_vec() || sximm !== '0) begin
            failures++;
            $display("FAIL reset_state: got %h sximm=%h required %h sximm=0", obs(), sximm, idle_vec());
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (obs() !== idle_vec()) begin
            failures++;
            $display("FAIL reset_release: got %h required %h", obs(), idle_vec());
        end
    endtask

    task automatic test_add();
        int lat, nwr;
        exec_cmd(3'd0, 3'd1, 3'd2, 3'd3, 2'b00, 8'h00, 0, 1'b0, lat, nwr);
        checks++;
        if (lat != 4 || nwr != 1) begin
            failures++;
            $display("FAIL add_latency: lat=%0d writes=%0d required 4 and 1", lat, nwr);
        end
    endtask

    task automatic test_cmp();
        int lat, nwr;
        exec_cmd(3'd6, 3'd4, 3'd4, 3'd2, 2'b00, 8'h00, 0, 1'b0, lat, nwr);
        checks++;
        if (lat != 3 || nwr != 0) begin
            failures++;
            $display("FAIL cmp_latency: lat=%0d writes=%0d required 3 and 0", lat, nwr);
        end
    endtask

    task automatic test_movi();
        int lat, nwr;
        exec_cmd(3'd5, 3'd0, 3'd0, 3'd5, 2'b00, 8'hF6, 0, 1'b0, lat, nwr);
        checks++;
        if (sximm !== 16'hFFF6 || lat != 1 || nwr != 1) begin
            failures++;
            $display("FAIL movi_neg: sximm=%h lat=%0d writes=%0d required FFF6 1 1", sximm, lat, nwr);
        end
        exec_cmd(3'd5, 3'd0, 3'd0, 3'd5, 2'b00, 8'h7F, 0, 1'b0, lat, nwr);
        checks++;
        if (sximm !== 16'h007F) begin
            failures++;
            $display("FAIL movi_pos: sximm=%h required 007F", sximm);
        end
    endtask

    task automatic test_back_to_back();
        int lat, nwr;
        exec_cmd(3'd3, 3'd0, 3'd6, 3'd1, 2'b01, 8'h00, 1, 1'b1, lat, nwr);
        checks++;
        if (lat != 3) begin
            failures++;
            $display("FAIL mvn_latency: lat=%0d required 3", lat);
        end
        exec_cmd(3'd4, 3'd0, 3'd7, 3'd2, 2'b00, 8'h00, 1, 1'b1, lat, nwr);
        exec_cmd(3'd5, 3'd0, 3'd0, 3'd4, 2'b00, 8'h80, 1, 1'b1, lat, nwr);
        exec_cmd(3'd5, 3'd0, 3'd0, 3'd6, 2'b00, 8'h01, 1, 1'b0, lat, nwr);
        checks++;
        if (lat != 1 || nwr != 1) begin
            failures++;
            $display("FAIL movi_b2b: lat=%0d writes=%0d required 1 1", lat, nwr);
        end
    endtask

    task automatic test_busy_start();
        int lat, nwr;
        exec_cmd(3'd1, 3'd2, 3'd3, 3'd4, 2'b10, 8'h00, 1, 1'b0, lat, nwr);
        // s is low again; no queued command may start.
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (obs() !== idle_vec()) begin
                failures++;
                $display("FAIL busy_s_ignored: got %h required %h", obs(), idle_vec());
            end
        end
    endtask

    task automatic test_reset_mid_exec();
        int lat, nwr;
        op = 3'd0; rn = 3'd1; rm = 3'd2; rd = 3'd3; shift_in = 2'b00; imm8 = 8'h55; s = 1'b1;
        @(posedge clk); #1 s = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (loadc !== 1'b1 || loads !== 1'b1) begin
            failures++;
            $display("FAIL add_in_exec: loadc=%b loads=%b required 1 1", loadc, loads);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (obs() !== idle_vec() || sximm !== '0) begin
            failures++;
            $display("FAIL async_reset: got %h sximm=%h required %h sximm=0", obs(), sximm, idle_vec());
        end
        @(posedge clk); #1 reset = 1'b0;
        nwr = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (write === 1'b1) nwr++;
            checks++;
            if (w !== 1'b1 || write !== 1'b0) begin
                failures++;
                $display("FAIL after_reset: w=%b write=%b required 1 0", w, write);
            end
        end
        exec_cmd(3'd5, 3'd0, 3'd0, 3'd7, 2'b00, 8'hA5, 0, 1'b0, lat, nwr);
    endtask

    task automatic test_random();
        int lat, nwr, want;
        logic [2:0] o;
        for (int n = 0; n < 60; n++) begin
            o = 3'($urandom);
            exec_cmd(o, 3'($urandom), 3'($urandom), 3'($urandom), 2'($urandom),
                     8'($urandom), 2, 1'b0, lat, nwr);
            want = (o <= 3'd5) ? 1 : 0;
            checks++;
            if (nwr != want) begin
                failures++;
                $display("FAIL rand_writes op=%0d: got %0d required %0d", o, nwr, want);
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_cmp();
        test_movi();
        test_back_to_back();
        test_busy_start();
        test_reset_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle control FSM that drives the register-file/ALU datapath from the issuing side. It accepts one register-to-register or immediate command per handshake. It then sequences operand reads into the A/B registers, the ALU execute into C and status, and the write-back into the destination register. It sits between the instruction source (test bench now, instruction decoder later) and the existing datapath control inputs.

## Interface
Parameters:
- DW, 16, datapath width; immediate sign-extension target width.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; one clock; forces idle.
- s  in  1  start request; sampled only while w=1.
- op  in  3  command: 000 ADD, 001 SUB, 010 AND, 011 MVN, 100 MOV Rm, 101 MOVI, 110 CMP; 111 reserved.
- rn, rm, rd  in  3 each  source A, source B, destination register numbers.
- shift_in  in  2  shift code applied to B operand.
- imm8  in  8  immediate for MOVI.
- w  out  1  idle/ready; 1 only in WAIT.
- readnum, writenum  out  3  register-file addresses.
- write, loada, loadb, loadc, loads  out  1  register enables.
- asel, bsel  out  1  1 selects zero for A and selects the immediate for B, respectively.
- vsel  out  2  write-back source: 00 C, 10 sximm.
- shift  out  2  datapath shifter code.
- ALUop  out  2  00 add, 01 sub, 10 and, 11 not-B.
- sximm  out  DW  imm8 sign-extended to DW bits.

## Operation
- Acceptance: in WAIT with s=1 at a rising edge, capture op, rn, rm, rd, shift_in and imm8 into command registers. The FSM leaves WAIT on that edge. All outputs decode from state plus captured fields, never from live inputs.
- Reserved op 111: accepted, returns straight to WAIT, and asserts no enables.
- States: WAIT, GET_A, GET_B, EXEC, WR_C, WR_IMM.
- ADD/SUB/AND path: WAIT→GET_A→GET_B→EXEC→WR_C→WAIT.
- CMP path: WAIT→GET_A→GET_B→EXEC→WAIT. CMP uses ALUop=01 and performs no write.
- MVN/MOV Rm path: WAIT→GET_B→EXEC→WR_C→WAIT. MOV uses asel=1 and ALUop=00. MVN uses ALUop=11.
- MOVI path: WAIT→WR_IMM→WAIT.
- Outputs by state:
  - GET_A: readnum=rn, loada=1.
  - GET_B: readnum=rm, loadb=1.
  - EXEC: shift=captured shift, ALUop per op, loads=1, loadc=1 except for CMP (loadc=0).
  - WR_C: writenum=rd, vsel=00, write=1.
  - WR_IMM: writenum=rd, vsel=10, bsel=1, write=1.
- Any enable not listed for a state is 0. readnum, writenum, shift and ALUop are 0 when not used.
- sximm is combinational from captured imm8: {{DW-8{imm8[7]}}, imm8}.
- Status Z itself is produced by the datapath. This block only asserts loads.

## Timing
- Reset (asynchronous, any cycle, including mid-sequence): state=WAIT and w=1 immediately. All enables, vsel, shift, ALUop, readnum and writenum go to 0. Command registers clear to 0, so sximm=0. The interrupted command is abandoned with no partial write.
- Latency from accepting edge to return to WAIT:
  - ADD/SUB/AND: 4 cycles.
  - MVN/MOV: 3 cycles.
  - CMP: 3 cycles.
  - MOVI: 1 cycle.
  - Reserved: 1 cycle.
- w falls on the cycle after acceptance and rises in the cycle the FSM re-enters WAIT.
- s held high continuously issues the next command on the first WAIT edge. Back-to-back MOVI therefore runs at 2 cycles per command.
- s asserted while w=0 is ignored and not queued. Input changes while busy have no effect.
- Exactly one write pulse of 1 cycle per writing command. write and loadc are never asserted in the same cycle.

## Structure
- Package alu_seq_pkg holds:
  - the state enum;
  - the op code localparams (OP_ADD…OP_CMP);
  - the ALUop codes;
  - the vsel codes.
- Single module, no sub-module. The next-state block and the output decode live in the same file.

## Test plan
- Reset mid-EXEC of ADD, then release → w=1, all enables 0, no write pulse observed; next MOVI completes normally.
- ADD rn=1, rm=2, rd=3, shift=00 → cycles 1–4 show exactly, in order:
  - loada with readnum=1;
  - loadb with readnum=2;
  - loadc, loads with ALUop=00;
  - write with writenum=3, vsel=00.
  - w=1 on cycle 5.
- CMP rn=4, rm=4 → EXEC has ALUop=01, loads=1, loadc=0. No write in any cycle. w returns after 3 cycles.
- MOVI rd=5, imm8=8'hF6 → one cycle with write=1, writenum=5, vsel=10, sximm=16'hFFF6. A second MOVI with imm8=8'h7F gives sximm=16'h007F.
- MVN rm=6, shift=01 then MOV rm=7 with s held high → GET_A skipped for both. EXEC shows ALUop=11/shift=01, then ALUop=00/asel=1. No gap beyond a single WAIT cycle.
- s pulsed during busy cycles of SUB → ignored; exactly one command executed.
